// File: rtl/serial_left_shift_by_amount_if.sv
// rtl/serial_left_shift_by_amount_if.sv - operand/result valid-ready bundle for the serial left shifter
interface serial_left_shift_by_amount_if #(
    parameter int N  = 8,
    parameter int SW = 4
);
    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_data;
    logic [SW-1:0] up_shift;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;

    // master is the operand source and result sink; slave is the shifter
    modport master (
        output up_valid, up_data, up_shift, down_ready,
        input  up_ready, down_valid, down_data
    );

    modport slave (
        input  up_valid, up_data, up_shift, down_ready,
        output up_ready, down_valid, down_data
    );
endinterface

// File: rtl/serial_left_shift_by_amount.sv
// rtl/serial_left_shift_by_amount.sv - logical left shift by a run-time amount, one bit per clock
module serial_left_shift_by_amount #(
    parameter int N  = 8,
    parameter int SW = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_left_shift_by_amount_if.slave  bus,
    output logic                          busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  data_r;
    logic [SW-1:0] cnt_r;
    logic          accept;

    // up_ready depends only on state and down_ready, never on up_valid
    assign bus.up_ready   = (state == IDLE) || ((state == DONE) && bus.down_ready);
    assign bus.down_valid = (state == DONE);
    assign bus.down_data  = data_r;
    assign busy           = (state == SHIFT);
    assign accept         = bus.up_valid && bus.up_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            data_r <= '0;
            cnt_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_r <= bus.up_data;
                        cnt_r  <= bus.up_shift;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // amounts >= N simply run out the count and leave zero
                    if (cnt_r != '0) begin
                        data_r <= {data_r[N-2:0], 1'b0};
                        cnt_r  <= cnt_r - SW'(1);
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.down_ready) begin
                        if (accept) begin
                            data_r <= bus.up_data;
                            cnt_r  <= bus.up_shift;
                            state  <= SHIFT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_left_shift_by_amount.sv
// tb/tb_serial_left_shift_by_amount.sv - scoreboard bench for the serial left shifter
module tb_serial_left_shift_by_amount;
    localparam int N  = 8;
    localparam int SW = 4;

    typedef struct {
        logic [N-1:0] data;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    serial_left_shift_by_amount_if #(.N(N), .SW(SW)) bus ();

    serial_left_shift_by_amount #(.N(N), .SW(SW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t sb[$];
    int   rise_q[$];
    bit   in_result   = 1'b0;
    logic [N-1:0] exp_data;

    always @(posedge clk) cyc <= cyc + 1;

    // result monitor: checks data every valid cycle, latency at each rising down_valid
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            in_result = 1'b0;
        end else begin
            if (bus.down_valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: down_data=%h with nothing outstanding at cycle %0d",
                             bus.down_data, cyc);
                end else begin
                    if (!in_result) begin
                        rise_q.push_back(cyc);
                        vectors++;
                        if (cyc !== sb[0].cyc) begin
                            miscompares++;
                            $display("FAIL latency: down_valid rose at cycle %0d, required %0d", cyc, sb[0].cyc);
                        end
                    end
                    vectors++;
                    if (bus.down_data !== sb[0].data) begin
                        miscompares++;
                        $display("FAIL down_data: got %h, required %h at cycle %0d", bus.down_data, sb[0].data, cyc);
                    end
                    if (bus.down_ready) void'(sb.pop_front());
                end
                in_result = !bus.down_ready;
            end
            if (bus.up_valid && bus.up_ready) begin
                exp_data = bus.up_data << bus.up_shift;
                sb.push_back('{exp_data, cyc + int'(bus.up_shift) + 2});
            end
        end
    end

    task automatic send(input logic [N-1:0] d, input logic [SW-1:0] s, output bit in_done);
        bit ok = 1'b0;
        in_done      = 1'b0;
        bus.up_valid = 1'b1;
        bus.up_data  = d;
        bus.up_shift = s;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.up_ready) begin
                ok      = 1'b1;
                in_done = bus.down_valid;
                break;
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL accept_timeout: up_ready=%b, required 1 within 100 cycles", bus.up_ready);
        end
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
        bus.up_data  = N'($urandom);
        bus.up_shift = SW'($urandom);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.up_ready && !bus.down_valid && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL idle_timeout: outstanding=%0d, required 0 within 200 cycles", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        bus.up_valid   = 1'b1;
        bus.up_data    = N'($urandom);
        bus.up_shift   = SW'($urandom);
        bus.down_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.up_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_up_ready: got %b, required 1", bus.up_ready);
        end
        vectors++;
        if (bus.down_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_down_valid: got %b, required 0", bus.down_valid);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        vectors++;
        if (bus.down_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_down_data: got %h, required 00", bus.down_data);
        end
        bus.up_valid = 1'b0;
        rst          = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.up_ready, bus.down_valid, busy, bus.down_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
                miscompares++;
                $display("FAIL idle_hold: up_ready=%b down_valid=%b busy=%b down_data=%h, required 1 0 0 00",
                         bus.up_ready, bus.down_valid, busy, bus.down_data);
            end
            bus.up_data  = N'($urandom);
            bus.up_shift = SW'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        bit f;
        bus.down_ready = 1'b1;
        send(8'hB5, 4'd3, f);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_shift: got %b, required 1", busy);
        end
        wait_idle();
        send(8'hB5, 4'd0, f);
        wait_idle();
    endtask

    task automatic test_overshift();
        bit f;
        bus.down_ready = 1'b1;
        send(8'hFF, 4'd8, f);
        wait_idle();
        send(8'hFF, 4'd15, f);
        wait_idle();
        send(8'h01, 4'd7, f);
        wait_idle();
    endtask

    task automatic test_backpressure();
        bit f;
        bit seen = 1'b0;
        bus.down_ready = 1'b0;
        send(8'h05, 4'd3, f);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.down_valid) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL stall_valid_timeout: down_valid=%b, required 1", bus.down_valid);
        end
        @(posedge clk);
        #1;
        bus.up_valid = 1'b1;
        bus.up_data  = 8'hAA;
        bus.up_shift = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({bus.down_valid, bus.down_data, bus.up_ready} !== {1'b1, 8'h28, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold: down_valid=%b down_data=%h up_ready=%b, required 1 28 0",
                         bus.down_valid, bus.down_data, bus.up_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.up_valid   = 1'b0;
        bus.down_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        bit f;
        bus.down_ready = 1'b1;
        send(8'h0A, 4'd2, f);
        send(8'h03, 4'd1, f);
        vectors++;
        if (f !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept_in_done: accepted while down_valid=%b, required 1", f);
        end
        wait_idle();
        rise_q.delete();
        for (int i = 0; i < 4; i++) send(N'(8'h11 + 8'(i)), 4'd2, f);
        wait_idle();
        vectors++;
        if (rise_q.size() !== 4) begin
            miscompares++;
            $display("FAIL stream_count: got %0d results, required 4", rise_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (rise_q[i+1] - rise_q[i] !== 4) begin
                    miscompares++;
                    $display("FAIL stream_spacing: got %0d cycles, required 4", rise_q[i+1] - rise_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        bit f;
        bit stale = 1'b0;
        bus.down_ready = 1'b1;
        send(8'h11, 4'd10, f);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus.down_valid, bus.up_ready, busy} !== {1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: down_valid=%b up_ready=%b busy=%b, required 0 1 0",
                     bus.down_valid, bus.up_ready, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.down_valid) stale = 1'b1;
        end
        vectors++;
        if (stale !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_result: down_valid seen=%b after reset, required 0", stale);
        end
        @(posedge clk);
        #1;
        send(8'h11, 4'd1, f);
        wait_idle();
    endtask

    initial begin
        bus.up_valid   = 1'b0;
        bus.up_data    = '0;
        bus.up_shift   = '0;
        bus.down_ready = 1'b0;
        test_reset();
        test_basic();
        test_overshift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_left_shift_by_amount.md
# serial_left_shift_by_amount

Sequential, parameterized logical left shifter that moves an N-bit unsigned operand left by a run-time amount, one bit position per clock. It complements the combinational right-shift variants. It is used where a full barrel shifter is too large and latency is acceptable. Operands enter through a valid/ready upstream handshake and results leave through a valid/ready downstream handshake.

## Interface
- N, default 8: operand and result width in bits, N >= 2.
- SW, default 4: shift-amount width in bits; the amount range is 0 .. 2^SW - 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; rst == 0 forces the reset state immediately.
- up_valid  input  1  operand and amount are presented.
- up_ready  output  1  the block can accept an operand this cycle.
- up_data  input  N  unsigned operand.
- up_shift  input  SW  left-shift amount.
- down_valid  output  1  a result is presented.
- down_ready  input  1  the sink accepts the result this cycle.
- down_data  output  N  result, equal to (up_data << up_shift) truncated to N bits.
- busy  output  1  high in the SHIFT state.

## Operation
- States: IDLE, SHIFT, DONE. Internal registers: data_r (N bits) and cnt_r (SW bits).
- IDLE:
  - up_ready = 1.
  - On up_valid: data_r <= up_data, cnt_r <= up_shift, next state SHIFT.
- SHIFT:
  - up_ready = 0.
  - If cnt_r != 0: data_r <= {data_r[N-2:0], 1'b0} and cnt_r <= cnt_r - 1.
  - If cnt_r == 0: next state DONE, data_r unchanged.
- DONE:
  - down_valid = 1, down_data = data_r.
  - down_ready = 0: hold state; data_r is stable.
  - down_ready = 1 and up_valid = 0: next state IDLE.
  - down_ready = 1 and up_valid = 1: back-to-back acceptance. up_ready = down_ready in DONE. The new operand and amount load into data_r/cnt_r and the next state is SHIFT.
- Arithmetic:
  - Logical shift only; vacated LSBs are 0 and bits shifted past bit N-1 are discarded.
  - Amount >= N is legal and yields down_data = 0 after the full count runs. No clamping.
- Inputs are sampled only on a handshake cycle. up_data and up_shift are don't-care otherwise.
- The down_valid/down_data contract: once down_valid rises, it stays high and down_data stays constant until down_ready is sampled high.
- down_data is driven from data_r in every state, but is meaningful only while down_valid = 1.

## Timing
- Reset values:
  - State = IDLE.
  - up_ready = 1, down_valid = 0, busy = 0.
  - data_r = 0, cnt_r = 0, so down_data = 0.
- Latency: an operand accepted at edge k makes down_valid = 1 after edge k + up_shift + 1.
  - Amount 0 gives down_valid after edge k + 1.
  - Amount 2^SW - 1 gives down_valid after edge k + 2^SW.
- Throughput:
  - Back-to-back with down_ready held high: one result per up_shift + 2 cycles. Cycles are SHIFT × (s + 1) followed by DONE × 1.
  - No cycle is lost between DONE and the next SHIFT.
- Reset mid-operation (rst low in SHIFT or DONE):
  - Returns to IDLE asynchronously.
  - The in-flight result is discarded; down_valid drops without a handshake.
- up_ready, down_valid and busy are pure decodes of the registered state plus down_ready (DONE only). There is no combinational path from up_valid to up_ready.

## Test plan
- Reset and idle:
  - Drive rst = 0 with random inputs, then release.
  - Required: up_ready = 1, down_valid = 0, busy = 0, down_data = 0.
  - With up_valid held low for 10 cycles, the outputs do not change.
- Basic shifts, N = 8, down_ready = 1:
  - up_data = 8'hB5, up_shift = 3 gives down_data = 8'hA8 with down_valid after acceptance edge + 4.
  - up_shift = 0 gives 8'hB5 after edge + 1.
- Overshift:
  - up_data = 8'hFF with up_shift = 8 gives 8'h00.
  - up_data = 8'hFF with up_shift = 15 gives 8'h00 after edge + 16.
  - up_data = 8'h01 with up_shift = 7 gives 8'h80.
- Backpressure:
  - Result 8'h28 (8'h05 shifted by 3) presented with down_ready = 0 for 5 cycles.
  - Required: down_valid stays 1, down_data stays 8'h28, up_ready stays 0.
  - Required: an up_valid asserted during the stall is not accepted.
- Back-to-back:
  - In DONE, with down_ready = 1 and up_valid = 1 in the same cycle carrying 8'h03 shifted by 1.
  - Required: the first result completes, the new operand loads, and 8'h06 appears 2 cycles later.
  - Required: for a stream of 4 operands with amount 2, results are spaced exactly 4 cycles apart.
- Reset mid-shift:
  - Accept 8'h11 with up_shift = 10, then assert rst after 4 cycles.
  - Required: down_valid = 0 and up_ready = 1 immediately; after release, no stale result ever appears.
  - Required: the next operand 8'h11 shifted by 1 returns 8'h22.
